// File: rtl/nurse_call_arbiter.sv
// Nurse-call panel front end: synchronizes and debounces bed buttons, latches pending calls,
// serves one bed at a time in fixed priority (bed 0 first) and escalates unacknowledged calls.
module nurse_call_arbiter #(
  parameter int          N_BED       = 3,
  parameter logic [20:0] DEB_MAX     = 21'd1999999,
  parameter logic [31:0] TIMEOUT_MAX = 32'd999999999,
  parameter logic [24:0] BLINK_HALF  = 25'd24999999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BED-1:0] call,
  input  logic             ack,
  output logic [N_BED-1:0] led,
  output logic [N_BED-1:0] grant,
  output logic             busy,
  output logic             alarm,
  output logic [3:0]       pend_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE, ESCALATE} state_t;

  state_t           state;
  logic [N_BED-1:0] sync1, sync2, deb, pend;
  logic [N_BED-1:0] rise, clr, first;
  logic [20:0]      deb_cnt [N_BED];
  logic [31:0]      timer;
  logic [24:0]      blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < N_BED; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= call;
      sync2 <= sync1;
      for (int i = 0; i < N_BED; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 21'd1;
        end
      end
    end
  end

  // A rise is the edge on which the debounced value is about to flip 0->1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < N_BED; i++)
      rise[i] = ~deb[i] & sync2[i] & (deb_cnt[i] == DEB_MAX);
  end

  assign clr = (ack && state != IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr) | rise;
  end

  always_comb begin
    first = '0;
    for (int i = N_BED - 1; i >= 0; i--) begin
      if (pend[i]) begin
        first    = '0;
        first[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N_BED; i++) pend_cnt = pend_cnt + {3'b000, pend[i]};
  end

  assign led = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      alarm <= 1'b0;
      timer <= '0;
      blink <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend != '0) begin
            grant <= first;
            timer <= '0;
            busy  <= 1'b1;
            state <= SERVE;
          end
        end
        SERVE: begin
          timer <= timer + 32'd1;
          if (ack) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TIMEOUT_MAX) begin
            alarm <= 1'b1;
            blink <= '0;
            state <= ESCALATE;
          end
        end
        ESCALATE: begin
          if (ack) begin
            grant <= '0;
            busy  <= 1'b0;
            alarm <= 1'b0;
            blink <= '0;
            state <= IDLE;
          end else if (blink == BLINK_HALF) begin
            alarm <= ~alarm;
            blink <= '0;
          end else begin
            blink <= blink + 25'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nurse_call_arbiter.sv
// Self-checking bench for nurse_call_arbiter: directed table, corner sequences and a
// randomized run, all compared against a behavioural model of the panel rules.
module tb_nurse_call_arbiter;

  localparam int N   = 3;
  localparam int DEB = 3;
  localparam int TMO = 20;
  localparam int BLK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] call;
  logic       ack;
  logic [2:0] led, grant;
  logic       busy, alarm;
  logic [3:0] pend_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nurse_call_arbiter #(
    .N_BED(N), .DEB_MAX(21'd3), .TIMEOUT_MAX(32'd20), .BLINK_HALF(25'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call(call), .ack(ack),
    .led(led), .grant(grant), .busy(busy), .alarm(alarm), .pend_cnt(pend_cnt)
  );

  // Model: buttons seen two edges late, accepted after DEB+1 consecutive differing samples;
  // service age counted in edges since grant decides escalation and blink phase.
  logic [2:0] call_hist [$];
  logic [2:0] s_hist [$];
  logic [2:0] m_d, m_pend;
  bit         m_serving;
  int         m_idx, m_age;

  task automatic model_reset();
    call_hist.delete();
    call_hist.push_back(3'b000);
    call_hist.push_back(3'b000);
    s_hist.delete();
    m_d = '0; m_pend = '0; m_serving = 0; m_idx = 0; m_age = 0;
  endtask

  function automatic logic [2:0] m_grant();
    logic [2:0] g;
    g = '0;
    if (m_serving) g[m_idx] = 1'b1;
    return g;
  endfunction

  function automatic logic m_alarm();
    return m_serving && (m_age >= TMO + 1) && (((m_age - TMO - 1) / (BLK + 1)) % 2 == 0);
  endfunction

  task automatic model_step(input logic [2:0] c, input logic a);
    logic [2:0] s, rise, clr, old_pend, new_d;
    s = call_hist.pop_front();
    call_hist.push_back(c);
    s_hist.push_back(s);
    if (s_hist.size() > DEB + 1) void'(s_hist.pop_front());
    rise = '0;
    new_d = m_d;
    for (int i = 0; i < N; i++) begin
      bit all_diff;
      all_diff = (s_hist.size() == DEB + 1);
      foreach (s_hist[j]) if (s_hist[j][i] == m_d[i]) all_diff = 0;
      if (all_diff) begin
        new_d[i] = ~m_d[i];
        rise[i]  = new_d[i];
      end
    end
    clr = (m_serving && a) ? m_grant() : 3'b000;
    old_pend = m_pend;
    if (!m_serving) begin
      if (old_pend != 0) begin
        for (int i = N - 1; i >= 0; i--) if (old_pend[i]) m_idx = i;
        m_serving = 1;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (a) m_serving = 0;
    end
    m_pend = (old_pend & ~clr) | rise;
    m_d = new_d;
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_pack();
    return {4'b0, led, grant, busy, alarm, pend_cnt};
  endfunction

  task automatic checkOutput(input string tag);
    logic [15:0] exp;
    exp = {4'b0, m_pend, m_grant(), m_serving, m_alarm(), 4'($countones(m_pend))};
    check_val(tag, dut_pack(), exp);
    check_val({tag, "_invariant"}, 16'(($onehot0(grant)) && ((grant & ~led) == 3'b000)), 16'd1);
  endtask

  // Called just after a posedge: drive inputs, take one edge, compare 1 time unit later.
  task automatic applyStimulus(input logic [2:0] c, input logic a);
    call = c;
    ack  = a;
    @(posedge clk);
    model_step(c, a);
    #1;
    checkOutput("model");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(3'b000, 1'b0);
  endtask

  typedef struct {
    logic [2:0] call;
    logic       ack;
    int         n;
    logic [2:0] led;
    logic [2:0] grant;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] lvl;
    int hold [3];

    tbl[0]  = '{3'b110, 1'b0, 5, 3'b000, 3'b000, 1'b0, 4'd0};
    tbl[1]  = '{3'b110, 1'b0, 1, 3'b110, 3'b000, 1'b0, 4'd2};
    tbl[2]  = '{3'b110, 1'b0, 1, 3'b110, 3'b010, 1'b1, 4'd2};
    tbl[3]  = '{3'b000, 1'b1, 1, 3'b100, 3'b000, 1'b0, 4'd1};
    tbl[4]  = '{3'b000, 1'b0, 1, 3'b100, 3'b100, 1'b1, 4'd1};
    tbl[5]  = '{3'b000, 1'b1, 1, 3'b000, 3'b000, 1'b0, 4'd0};
    tbl[6]  = '{3'b000, 1'b0, 8, 3'b000, 3'b000, 1'b0, 4'd0};
    tbl[7]  = '{3'b100, 1'b0, 6, 3'b100, 3'b000, 1'b0, 4'd1};
    tbl[8]  = '{3'b000, 1'b0, 1, 3'b100, 3'b100, 1'b1, 4'd1};
    tbl[9]  = '{3'b001, 1'b0, 6, 3'b101, 3'b100, 1'b1, 4'd2};
    tbl[10] = '{3'b000, 1'b1, 1, 3'b001, 3'b000, 1'b0, 4'd1};
    tbl[11] = '{3'b000, 1'b0, 1, 3'b001, 3'b001, 1'b1, 4'd1};
    tbl[12] = '{3'b000, 1'b1, 1, 3'b000, 3'b000, 1'b0, 4'd0};

    rst_n = 1'b0;
    call  = 3'b000;
    ack   = 1'b0;
    model_reset();
    #1;
    check_val("reset_state", dut_pack(), 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Priority and no-preemption table
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) applyStimulus(tbl[r].call, tbl[r].ack);
      check_val($sformatf("table_row%0d", r), dut_pack(),
                {4'b0, tbl[r].led, tbl[r].grant, tbl[r].busy, 1'b0, tbl[r].cnt});
    end
    idle(8);

    // Bounce: 20 cycles of toggling, then hold; latch exactly on the 6th held edge
    for (int k = 0; k < 20; k++) applyStimulus(((k / 2) % 2 == 0) ? 3'b010 : 3'b000, 1'b0);
    for (int h = 1; h <= 6; h++) begin
      applyStimulus(3'b010, 1'b0);
      check_val($sformatf("bounce_h%0d", h), {13'b0, led}, (h < 6) ? 16'h0 : 16'h2);
    end
    applyStimulus(3'b000, 1'b0);
    check_val("bounce_grant", {13'b0, grant}, 16'h2);
    applyStimulus(3'b000, 1'b1);
    check_val("bounce_ack", {13'b0, led}, 16'h0);
    idle(8);

    // Escalation timing
    for (int k = 0; k < 6; k++) applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b000, 1'b0);
    check_val("esc_grant", {13'b0, grant}, 16'h2);
    for (int k = 1; k <= 35; k++) begin
      applyStimulus(3'b000, 1'b0);
      if (k == 20 || k == 26 || k == 30) check_val($sformatf("esc_alarm_k%0d", k), {15'b0, alarm}, 16'h0);
      if (k == 21 || k == 25 || k == 31) check_val($sformatf("esc_alarm_k%0d", k), {15'b0, alarm}, 16'h1);
    end
    applyStimulus(3'b000, 1'b1);
    check_val("esc_ack", {12'b0, grant, alarm}, 16'h0);
    idle(8);

    // Set/clear collision on bed 1
    for (int k = 0; k < 6; k++) applyStimulus(3'b010, 1'b0);
    check_val("coll_pend", {13'b0, led}, 16'h2);
    for (int k = 0; k < 6; k++) applyStimulus(3'b000, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b1);
    check_val("coll_same_edge", {9'b0, led, grant, busy}, {9'b0, 3'b010, 3'b000, 1'b0});
    applyStimulus(3'b000, 1'b0);
    check_val("coll_regrant", {13'b0, grant}, 16'h2);
    applyStimulus(3'b000, 1'b1);
    idle(8);

    // Asynchronous reset in the middle of escalation
    for (int k = 0; k < 6; k++) applyStimulus(3'b111, 1'b0);
    check_val("rst_pend_all", {13'b0, led}, 16'h7);
    applyStimulus(3'b000, 1'b0);
    for (int k = 0; k < 24; k++) applyStimulus(3'b000, 1'b0);
    check_val("rst_pre_escalate", {11'b0, grant, busy, alarm}, {11'b0, 3'b001, 1'b1, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_clear", dut_pack(), 16'h0000);
    model_reset();
    call = 3'b000;
    ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    check_val("rst_after_release", dut_pack(), 16'h0000);

    // Randomized run: buttons held for random stretches, occasional acks
    lvl = 3'b000;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = ($urandom_range(0, 1) == 1);
          hold[i] = $urandom_range(1, 12);
        end else begin
          hold[i]--;
        end
      end
      applyStimulus(lvl, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
